// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - two-flop synchronizer plus qualify-then-commit debouncer
// Emits registered level, one-cycle edge strobes and a saturating abort count.
module debounce_filter #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       raw_in,
   output logic       d_out,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic       busy,
   output logic [7:0] bounce_cnt
);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [7:0]           bounce_q, bounce_d;
   logic                 s1_q, s2_q;
   logic                 d_out_q, d_out_d;
   logic                 busy_q, busy_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         state_q  <= IDLE_LOW;
         cnt_q    <= '0;
         bounce_q <= '0;
         d_out_q  <= 1'b0;
         busy_q   <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         s1_q     <= raw_in;
         s2_q     <= s1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bounce_q <= bounce_d;
         d_out_q  <= d_out_d;
         busy_q   <= busy_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bounce_d = bounce_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (s2_q) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = IDLE_HIGH;
                  cnt_d   = '0;
                  rise_d  = 1'b1;
               end else begin
                  state_d = WAIT_HIGH;
                  cnt_d   = CNT_ONE;
               end
            end else begin
               cnt_d = '0;
            end
         end
         WAIT_HIGH: begin
            if (s2_q) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = IDLE_HIGH;
                  cnt_d   = '0;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               // Abort: partial count is dropped, next attempt starts from zero.
               state_d = IDLE_LOW;
               cnt_d   = '0;
               if (bounce_q != 8'hFF) bounce_d = bounce_q + 8'd1;
            end
         end
         IDLE_HIGH: begin
            if (!s2_q) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = IDLE_LOW;
                  cnt_d   = '0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = WAIT_LOW;
                  cnt_d   = CNT_ONE;
               end
            end else begin
               cnt_d = '0;
            end
         end
         WAIT_LOW: begin
            if (!s2_q) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = IDLE_LOW;
                  cnt_d   = '0;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
               if (bounce_q != 8'hFF) bounce_d = bounce_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Level and busy are registered copies of what the next state implies.
   assign d_out_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
   assign busy_d  = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);

   assign d_out      = d_out_q;
   assign busy       = busy_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign bounce_cnt = bounce_q;

endmodule
